// File: rtl/riscv_arb_pkg.sv
// riscv_arb_pkg: shared FSM encoding and default starvation limit for the memory port arbiter
package riscv_arb_pkg;
  typedef enum logic [1:0] {IDLE, RESP_IF, RESP_DM} arb_state_t;
  localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: counts data grants while fetch waits and raises force_if at the limit
module arb_starve_cnt #(
  parameter int STARVE_MAX = 4
)(
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  input  logic dm_gnt,
  output logic force_if
);
  localparam int CW = $clog2(STARVE_MAX + 2);
  logic [CW-1:0] cnt;
  assign force_if = cnt == CW'(STARVE_MAX);
  // clear when fetch is served or idle, otherwise count data wins and saturate at the limit
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (!if_req || if_gnt) ? '0 : (dm_gnt && !force_if) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch/data arbiter onto one single-port memory; ARB_STARVE_GUARD_EN adds fetch anti-starvation
module mem_port_arbiter import riscv_arb_pkg::*; #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wmask,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              if_stall,
  output logic              dm_stall
);
  arb_state_t state;
  logic force_if;
`ifdef ARB_STARVE_GUARD_EN
  arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk(clk), .rst(rst), .if_req(if_req), .if_gnt(if_gnt), .dm_gnt(dm_gnt), .force_if(force_if)
  );
`else
  assign force_if = STARVE_MAX < 0;
`endif
  assign if_gnt    = ~rst & if_req & (~dm_req | force_if);
  assign dm_gnt    = ~rst & dm_req & ~if_gnt;
  assign if_stall  = if_req & ~if_gnt;
  assign dm_stall  = dm_req & ~dm_gnt;
  assign mem_en    = if_gnt | dm_gnt;
  assign mem_we    = dm_gnt & dm_we;
  assign mem_addr  = if_gnt ? if_addr : dm_addr;
  assign mem_wdata = dm_wdata;
  assign mem_wmask = mem_we ? dm_wmask : '0;
  assign if_rvalid = state == RESP_IF;
  assign dm_rvalid = state == RESP_DM;
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;
  // remember which requester owns the read data returning next cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= if_gnt ? RESP_IF : (dm_gnt && !dm_we) ? RESP_DM : IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a read-data scoreboard for mem_port_arbiter
module tb_mem_port_arbiter;
  logic        clk = 0, rst = 1;
  logic        if_req = 0, dm_req = 0, dm_we = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0;
  logic [3:0]  dm_wmask = 0;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, if_stall, dm_stall;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0]  mem_wmask;
  int checks = 0, errs = 0;
  logic [31:0] exp_if[$], exp_dm[$];

  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wmask(dm_wmask), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .if_stall(if_stall), .dm_stall(dm_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  always @(posedge clk) if (mem_en && !mem_we) mem_rdata <= pat(mem_addr);

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_dm_rvalid", dm_rvalid, 0);
    end else begin
      if (if_rvalid) begin
        if (exp_if.size() == 0) chk("if_spurious_rvalid", 1, 0);
        else chk("if_rdata", if_rdata, exp_if.pop_front());
      end
      if (dm_rvalid) begin
        if (exp_dm.size() == 0) chk("dm_spurious_rvalid", 1, 0);
        else chk("dm_rdata", dm_rdata, exp_dm.pop_front());
      end
    end
  end

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                       input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dwm);
    @(negedge clk);
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dwe; dm_addr = da; dm_wdata = dwd; dm_wmask = dwm;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    drive(1, 32'h100, 0, 0, 0, 0, 0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_if_stall", if_stall, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 0;
    drive(1, 32'h100, 0, 0, 0, 0, 0);
    chk("sole_if_gnt", if_gnt, 1);
    chk("sole_dm_gnt", dm_gnt, 0);
    chk("sole_mem_en", mem_en, 1);
    chk("sole_mem_addr", mem_addr, 32'h100);
    chk("sole_mem_we", mem_we, 0);
    exp_if.push_back(pat(32'h100));
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("resp_if_rvalid", if_rvalid, 1);
    chk("idle_mem_en", mem_en, 0);
    chk("idle_mem_wmask", mem_wmask, 0);
    drive(1, 32'h300, 1, 0, 32'h2000, 0, 0);
    chk("conf_dm_gnt", dm_gnt, 1);
    chk("conf_if_gnt", if_gnt, 0);
    chk("conf_if_stall", if_stall, 1);
    chk("conf_dm_stall", dm_stall, 0);
    chk("conf_mem_addr", mem_addr, 32'h2000);
    exp_dm.push_back(pat(32'h2000));
    drive(1, 32'h300, 0, 0, 0, 0, 0);
    chk("conf_dm_rvalid", dm_rvalid, 1);
    chk("conf_if_gnt2", if_gnt, 1);
    chk("conf_mem_addr2", mem_addr, 32'h300);
    exp_if.push_back(pat(32'h300));
    drive(0, 0, 1, 1, 32'h40, 32'hDEADBEEF, 4'h3);
    chk("st_dm_gnt", dm_gnt, 1);
    chk("st_mem_we", mem_we, 1);
    chk("st_mem_wmask", mem_wmask, 4'h3);
    chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st_mem_addr", mem_addr, 32'h40);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("st_no_rvalid", dm_rvalid, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'(4 * i), 0, 0, 0, 0, 0);
      chk("b2b_if_gnt", if_gnt, 1);
      chk("b2b_mem_addr", mem_addr, 32'(4 * i));
      if (i > 0) chk("b2b_if_rvalid", if_rvalid, 1);
      exp_if.push_back(pat(32'(4 * i)));
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("b2b_if_rvalid_last", if_rvalid, 1);
    drive(0, 0, 1, 0, 32'h2400, 0, 0);
    exp_dm.push_back(pat(32'h2400));
    drive(1, 32'h600, 0, 0, 0, 0, 0);
    chk("mix_dm_rvalid", dm_rvalid, 1);
    chk("mix_if_gnt", if_gnt, 1);
    exp_if.push_back(pat(32'h600));
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h500, 1, 0, 32'(32'h1000 + 4 * i), 0, 0);
`ifdef ARB_STARVE_GUARD_EN
      chk("starve_if_gnt", if_gnt, i % 5 == 4);
      chk("starve_dm_gnt", dm_gnt, i % 5 != 4);
      if (i % 5 == 4) exp_if.push_back(pat(32'h500));
      else exp_dm.push_back(pat(32'(32'h1000 + 4 * i)));
`else
      chk("starve_if_gnt", if_gnt, 0);
      chk("starve_dm_gnt", dm_gnt, 1);
      exp_dm.push_back(pat(32'(32'h1000 + 4 * i)));
`endif
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 32'h3000, 0, 0);
    chk("rstflt_dm_gnt", dm_gnt, 1);
    @(posedge clk);
    #1 rst = 1;
    dm_req = 0;
    #1 chk("rstflt_dm_rvalid", dm_rvalid, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rstflt_after_dm_rvalid", dm_rvalid, 0);
    drive(1, 32'h700, 0, 0, 0, 0, 0);
    chk("post_rst_if_gnt", if_gnt, 1);
    exp_if.push_back(pat(32'h700));
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("if_queue_drained", exp_if.size(), 0);
    chk("dm_queue_drained", exp_dm.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end
endmodule
